// File: rtl/cam_if_pkg.sv
// Shared definitions for the camera pattern source.
// Holds geometry defaults, RGB444 colour constants, pattern modes and FSM states.
package cam_if_pkg;

  localparam int DEF_TAM_LINE       = 320;
  localparam int DEF_TAM_ROW        = 120;
  localparam int DEF_BLACK_TAM_LINE = 4;
  localparam int DEF_BLACK_TAM_ROW  = 4;

  localparam logic [11:0] RGB_BLUE  = 12'h00F;
  localparam logic [11:0] RGB_GREEN = 12'h0F0;
  localparam logic [11:0] RGB_PINK  = 12'hF0F;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } cam_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cam_state_e;

  // Split an RGB444 pixel into its wire byte: even byte carries R, odd byte carries G and B.
  function automatic logic [7:0] rgb444_byte(input logic [11:0] p, input logic odd);
    return odd ? p[7:0] : {4'h0, p[11:8]};
  endfunction

endpackage

// File: rtl/cam_pattern_rgb444.sv
// Test-pattern generator: maps pixel coordinates and the latched frame settings
// to one RGB444 pixel. Purely combinational; only the low coordinate bits matter.
module cam_pattern_rgb444
  import cam_if_pkg::*;
(
  input  cam_mode_e   mode_i,
  input  logic [11:0] color_i,
  input  logic [3:0]  x_i,
  input  logic [3:0]  y_i,
  input  logic [3:0]  frame_cnt_i,
  output logic [11:0] pix_o
);

  // Pattern lookup for the selected mode
  always_comb begin
    pix_o = color_i;
    case (mode_i)
      MODE_SOLID:    pix_o = color_i;
      MODE_BARS:     pix_o = x_i[1] ? RGB_GREEN : RGB_BLUE;
      MODE_CHECKER:  pix_o = (x_i[3] ^ y_i[3]) ? RGB_PINK : RGB_GREEN;
      MODE_GRADIENT: pix_o = {x_i, y_i, frame_cnt_i};
      default:       pix_o = color_i;
    endcase
  end

endmodule

// File: rtl/cam_pattern_src.sv
// OV7670-style camera transmitter emulating the sensor side of the capture port.
// A clk divider makes CAM_pclk; every CAM_* sync/data register changes only on the
// falling pclk edge so the receiver (sampling on the rising edge) gets half a pclk
// of setup and hold.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no frame; vsync=1, href=0, data=0; waits for en on a pclk fall
//   ST_RUN  | streaming one byte per pclk; frames run to completion
module cam_pattern_src
  import cam_if_pkg::*;
#(
  parameter int PCLK_DIV       = 4,
  parameter int TAM_LINE       = DEF_TAM_LINE,
  parameter int TAM_ROW        = DEF_TAM_ROW,
  parameter int BLACK_TAM_LINE = DEF_BLACK_TAM_LINE,
  parameter int BLACK_TAM_ROW  = DEF_BLACK_TAM_ROW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [11:0] color,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_start,
  output logic        busy
);

  localparam int COL_MAX = TAM_LINE + BLACK_TAM_LINE - 1;
  localparam int ROW_MAX = TAM_ROW + BLACK_TAM_ROW - 1;
  localparam int COL_W   = $clog2(COL_MAX + 1);
  localparam int ROW_W   = $clog2(ROW_MAX + 1);
  localparam int DIV_W   = $clog2(PCLK_DIV);
  localparam int HALF    = PCLK_DIV / 2;

  if (PCLK_DIV < 2 || (PCLK_DIV % 2) != 0) begin : g_bad_div
    $error("cam_pattern_src: PCLK_DIV must be even and >= 2");
  end
  if ((BLACK_TAM_ROW % 2) != 0) begin : g_bad_brow
    $error("cam_pattern_src: BLACK_TAM_ROW must be even");
  end
  // Pattern lookup reads col[4:1] and row[3:0] directly.
  if (COL_W < 5 || ROW_W < 4) begin : g_bad_geom
    $error("cam_pattern_src: frame too small for pattern coordinates");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             pclk_q, pclk_d;
  logic             fall_stb;

  cam_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  cam_mode_e        mode_q, mode_d;
  logic [11:0]      color_q, color_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             start;

  logic             vsync_q, vsync_d;
  logic             href_q, href_d;
  logic [7:0]       data_q, data_d;
  logic             fs_q, fs_d;

  logic [3:0]       x_lo, y_lo;
  logic [11:0]      pix;

  // Pixel clock divider: high for the upper half of the count, falls on wrap
  always_comb begin
    fall_stb = (div_q == DIV_W'(PCLK_DIV - 1));
    div_d    = fall_stb ? '0 : div_q + 1'b1;
    pclk_d   = (div_d >= DIV_W'(HALF));
  end

  // Divider registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      pclk_q <= pclk_d;
    end
  end

  // Next state, byte position and per-frame latches; all advance on the pclk fall
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    mode_d  = mode_q;
    color_d = color_q;
    fcnt_d  = fcnt_q;
    start   = 1'b0;
    if (fall_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_RUN;
            col_d   = '0;
            row_d   = '0;
            start   = 1'b1;
          end
        end
        ST_RUN: begin
          if (col_q == COL_W'(COL_MAX)) begin
            col_d = '0;
            if (row_q == ROW_W'(ROW_MAX)) begin
              row_d  = '0;
              fcnt_d = fcnt_q + 4'd1;
              if (en) start = 1'b1;
              else    state_d = ST_IDLE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (start) begin
      mode_d  = cam_mode_e'(mode);
      color_d = color;
    end
  end

  // Coordinates of the byte about to be issued; y wraps mod 16, only low bits are used
  assign x_lo = col_d[4:1];
  assign y_lo = row_d[3:0] - 4'(BLACK_TAM_ROW);

  cam_pattern_rgb444 u_pattern (
    .mode_i      (mode_d),
    .color_i     (color_d),
    .x_i         (x_lo),
    .y_i         (y_lo),
    .frame_cnt_i (fcnt_d),
    .pix_o       (pix)
  );

  // Output byte for the upcoming position, loaded only on the pclk fall
  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    fs_d    = start;
    if (fall_stb) begin
      vsync_d = 1'b1;
      href_d  = 1'b0;
      data_d  = 8'h00;
      if (state_d == ST_RUN) begin
        vsync_d = (row_d < ROW_W'(BLACK_TAM_ROW / 2));
        href_d  = (row_d >= ROW_W'(BLACK_TAM_ROW)) && (col_d < COL_W'(TAM_LINE));
        data_d  = href_d ? rgb444_byte(pix, col_d[0]) : 8'h00;
      end
    end
  end

  // FSM, counters, latches and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      mode_q  <= MODE_SOLID;
      color_q <= 12'h000;
      fcnt_q  <= 4'd0;
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      fcnt_q  <= fcnt_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
    end
  end

  assign CAM_pclk    = pclk_q;
  assign CAM_vsync   = vsync_q;
  assign CAM_href    = href_q;
  assign CAM_px_data = data_q;
  assign frame_start = fs_q;
  assign busy        = (state_q == ST_RUN);

endmodule
